set_mode_ctrl: RTL

Button-driven setting controller for the clock/alarm. It converts three debounced button levels into rising-edge events, one per button. It sequences the display/counter datapath through run and edit modes, and issues single-cycle increment/decrement pulses with hold-to-repeat. It also returns to run mode after a period with no button activity, drives an edit-field blink, and toggles alarm enable.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/btn_rise_pulse.sv | 28 ++
 rtl/set_mode_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared mode encoding and button detector state for the clock/alarm
// setting logic.
package clock_pkg;

  localparam logic [2:0] MODE_RUN     = 3'd0;
  localparam logic [2:0] MODE_SET_HR  = 3'd1;
  localparam logic [2:0] MODE_SET_MIN = 3'd2;
  localparam logic [2:0] MODE_AL_HR   = 3'd3;
  localparam logic [2:0] MODE_AL_MIN  = 3'd4;
  localparam int         MODE_COUNT   = 5;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_EDGE,
    BTN_HELD
  } btn_st_t;

  function automatic logic [2:0] mode_next(input logic [2:0] m);
    if (int'(m) >= MODE_COUNT - 1)
      return MODE_RUN;
    return m + 3'd1;
  endfunction

endpackage

// File: rtl/btn_rise_pulse.sv
// Rising-edge detector for one debounced button level; the event is
// reported one cycle after the first high sample if still pressed.
module btn_rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);
  import clock_pkg::*;

  btn_st_t r_st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= BTN_IDLE;
    end else begin
      unique case (r_st)
        BTN_IDLE: r_st <= i_btn ? BTN_EDGE : BTN_IDLE;
        BTN_EDGE: r_st <= i_btn ? BTN_HELD : BTN_IDLE;
        BTN_HELD: r_st <= i_btn ? BTN_HELD : BTN_IDLE;
        default:  r_st <= BTN_IDLE;
      endcase
    end
  end

  assign o_rise = (r_st == BTN_EDGE) & i_btn;

endmodule

// File: rtl/set_mode_ctrl.sv
// Button-driven mode sequencer with inc/dec pulses, hold-to-repeat,
// idle timeout back to RUN, edit blink and alarm enable toggle.
module set_mode_ctrl #(
  parameter int REPEAT_DELAY   = 50000000,
  parameter int REPEAT_PERIOD  = 12500000,
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int BLINK_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [2:0] mode,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink,
  output logic       alarm_en
);
  import clock_pkg::*;

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RPT_MAX);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);

  localparam logic [RW-1:0] RPT_D = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_P = RW'(REPEAT_PERIOD - 1);
  localparam logic [IW-1:0] IDLE_TOP = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLK_TOP = BW'(BLINK_CYCLES - 1);

  logic [2:0]    r_mode;
  logic          r_inc;
  logic          r_dec;
  logic          r_blink;
  logic          r_alarm;
  logic          r_rep_act;
  logic          r_rep_dir;
  logic          r_rep_first;
  logic [RW-1:0] r_rep_cnt;
  logic [IW-1:0] r_idle;
  logic [BW-1:0] r_bcnt;

  logic w_ev_m;
  logic w_ev_i;
  logic w_ev_d;

  btn_rise_pulse u_det_mode (
    .clk(clk), .rst(rst), .i_btn(btn_mode), .o_rise(w_ev_m)
  );
  btn_rise_pulse u_det_inc (
    .clk(clk), .rst(rst), .i_btn(btn_inc), .o_rise(w_ev_i)
  );
  btn_rise_pulse u_det_dec (
    .clk(clk), .rst(rst), .i_btn(btn_dec), .o_rise(w_ev_d)
  );

  logic          w_edit;
  logic          w_both;
  logic          w_ev_any;
  logic          w_new_inc;
  logic          w_new_dec;
  logic          w_rep_lvl;
  logic          w_rep_hold;
  logic          w_rep_due;
  logic          w_pulse;
  logic          w_tout;
  logic          w_run_inc;
  logic [2:0]    w_mode_nxt;
  logic [RW-1:0] w_rep_top;

  assign w_edit    = (r_mode != MODE_RUN);
  assign w_both    = btn_inc & btn_dec;
  assign w_ev_any  = w_ev_m | w_ev_i | w_ev_d;
  assign w_new_inc = w_edit & w_ev_i & ~w_ev_m & ~w_both;
  assign w_new_dec = w_edit & w_ev_d & ~w_ev_m & ~w_both;
  assign w_rep_lvl = r_rep_dir ? btn_dec : btn_inc;
  assign w_rep_top = r_rep_first ? RPT_D : RPT_P;

  // Repeat survives only while its own button stays alone and held
  assign w_rep_hold = r_rep_act & w_rep_lvl & ~w_both &
                      ~w_ev_m & w_edit;
  assign w_rep_due  = w_rep_hold & (r_rep_cnt == w_rep_top);
  assign w_pulse    = w_new_inc | w_new_dec | w_rep_due;
  assign w_tout     = w_edit & ~w_ev_any & ~w_pulse &
                      (r_idle == IDLE_TOP);
  assign w_run_inc  = ~w_edit & w_ev_i & ~w_ev_m;

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_ev_m)
      w_mode_nxt = mode_next(r_mode);
    else if (w_tout)
      w_mode_nxt = MODE_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_RUN;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_blink     <= 1'b0;
      r_alarm     <= 1'b0;
      r_rep_act   <= 1'b0;
      r_rep_dir   <= 1'b0;
      r_rep_first <= 1'b0;
      r_rep_cnt   <= '0;
      r_idle      <= '0;
      r_bcnt      <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_inc  <= w_new_inc | (w_rep_due & ~r_rep_dir);
      r_dec  <= w_new_dec | (w_rep_due & r_rep_dir);
      if (w_run_inc)
        r_alarm <= ~r_alarm;

      if (w_new_inc | w_new_dec) begin
        r_rep_act   <= 1'b1;
        r_rep_dir   <= w_new_dec;
        r_rep_first <= 1'b1;
        r_rep_cnt   <= '0;
      end else if (w_rep_due) begin
        r_rep_first <= 1'b0;
        r_rep_cnt   <= '0;
      end else if (w_rep_hold) begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end else begin
        r_rep_act   <= 1'b0;
        r_rep_first <= 1'b0;
        r_rep_cnt   <= '0;
      end

      if (~w_edit | w_ev_any | w_pulse | w_tout)
        r_idle <= '0;
      else
        r_idle <= r_idle + IW'(1);

      if (w_mode_nxt == MODE_RUN) begin
        r_blink <= 1'b0;
        r_bcnt  <= '0;
      end else if (w_mode_nxt != r_mode) begin
        r_blink <= 1'b1;
        r_bcnt  <= '0;
      end else if (r_bcnt == BLK_TOP) begin
        r_blink <= ~r_blink;
        r_bcnt  <= '0;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end
  end

  assign mode      = r_mode;
  assign inc_pulse = r_inc;
  assign dec_pulse = r_dec;
  assign blink     = r_blink;
  assign alarm_en  = r_alarm;

endmodule
